debounce_pulse: RTL and testbench
=================================

DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: number of consecutive synchronized samples required to accept a level change; legal range is 2 to 2**CNT_W.
REQ-002 Parameter CNT_W, default 5: width of the stability counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset; the block resets when reset=0 at a rising clk edge.
REQ-005 Port btn_in, input, 1 bit: raw, asynchronous mechanical switch level, active-high.
REQ-006 Port en, input, 1 bit: block enable; when low, the FSM and counter hold.
REQ-007 Port pulse, output, 1 bit: registered one-cycle strobe on an accepted press; it drives the downstream counter's count-enable/T input.
REQ-008 Port level, output, 1 bit: registered debounced switch level.
REQ-009 Port busy, output, 1 bit: high while in WAIT_PRESS or WAIT_RELEASE.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer (s1, s2); all decisions use s2 only.
REQ-011 The FSM SHALL have states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
REQ-012 IDLE: s2=1 -> WAIT_PRESS with cnt=0; s2=0 -> stay.
REQ-013 WAIT_PRESS: s2=0 -> IDLE; s2=1 and cnt<STABLE_CYCLES-1 -> cnt+1; s2=1 and cnt==STABLE_CYCLES-1 -> PRESSED, level<=1, pulse<=1.
REQ-014 PRESSED: s2=0 -> WAIT_RELEASE with cnt=0; s2=1 -> stay.
REQ-015 WAIT_RELEASE: s2=1 -> PRESSED; s2=0 and cnt<STABLE_CYCLES-1 -> cnt+1; s2=0 and cnt==STABLE_CYCLES-1 -> IDLE, level<=0.
REQ-016 pulse SHALL be high for exactly one cycle per accepted press and low in every other cycle.
REQ-017 Latency: with btn_in stably high from the edge at which s1 first samples 1 (edge 1), pulse and level SHALL be high in the cycle after edge STABLE_CYCLES+3; release to level=0 has the same latency.
REQ-018 A glitch shorter than STABLE_CYCLES samples SHALL produce no pulse and no level change.
REQ-019 When en=0, state and cnt SHALL hold, pulse SHALL be 0 and level SHALL hold; the synchronizer keeps running.
REQ-020 If en falls in the cycle a pulse would be generated, that pulse SHALL be suppressed and re-evaluated when en rises.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-022 reset=0 at a rising edge SHALL set the state to IDLE and clear cnt, s1, s2, pulse and level; busy becomes 0.
REQ-023 Reset asserted mid-count SHALL abort the count; a button still held after reset is re-qualified from scratch, so pulse follows per REQ-017.
REQ-024 Reset SHALL take priority over en and btn_in.

Configuration
REQ-025 With macro DEBOUNCE_RELEASE_PULSE_EN defined, an output release_pulse (1 bit) SHALL be present, high for one cycle on the WAIT_RELEASE -> IDLE transition, gated by en, and reset to 0.
REQ-026 Without DEBOUNCE_RELEASE_PULSE_EN, the release_pulse port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package debounce_pkg SHALL hold the FSM state typedef (2-bit enum) and the default STABLE_CYCLES/CNT_W constants.
REQ-028 The synchronizer SHALL be a separate sub-module, sync2 (ports clk, reset, d, q), instantiated once.

Verification
REQ-029 Clean press: STABLE_CYCLES=16, btn_in 0->1 held 40 cycles -> exactly one pulse in the cycle after edge 19, level=1 from the same cycle.
REQ-030 Bounce: btn_in toggles every 3 cycles for 30 cycles, then stays high -> a single pulse, timed 19 edges after the final rising sample; no pulse during the bounce.
REQ-031 Short glitch: btn_in high for 10 cycles -> pulse=0 and level=0 throughout; busy rises then returns to 0.
REQ-032 Reset mid-count: reset=0 for 1 cycle at cnt=8 while btn_in is held -> all outputs 0 the next cycle; pulse 19 edges after reset release.
REQ-033 Enable hold: en=0 for 5 cycles while in WAIT_PRESS -> pulse delayed by exactly 5 cycles.
REQ-034 With DEBOUNCE_RELEASE_PULSE_EN defined: press then release held 40 cycles -> one release_pulse 19 edges after the first low sample; level=0 in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the debounce_pulse block.
// State enum is 2 bits; defaults give a 16-sample qualification window.
package debounce_pkg;

  localparam int STABLE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF         = 5;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

  // Qualifying states, i.e. a level change is being timed.
  function automatic logic is_busy(state_e s);
    return (s == ST_WAIT_PRESS) || (s == ST_WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/debounce_pulse_sync2.sv
// Two-flop synchronizer for the raw switch level; 2-cycle latency, no backpressure.
// Both stages clear on synchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Switch debouncer: press accepted after STABLE_CYCLES+1 stable samples, then a one-cycle pulse.
// Define DEBOUNCE_RELEASE_PULSE_EN to add a release_pulse strobe on accepted release.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic en,
  output logic pulse,
  output logic level,
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  output logic release_pulse,
`endif
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s2)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // With en low everything holds and pulse_d stays 0, so a pending accept is retried later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (s2) begin
            state_d = ST_WAIT_PRESS;
            cnt_d   = '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (!s2) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_PRESSED;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!s2) begin
            state_d = ST_WAIT_RELEASE;
            cnt_d   = '0;
          end
        end
        ST_WAIT_RELEASE: begin
          if (s2) begin
            state_d = ST_PRESSED;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_IDLE;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign busy  = is_busy(state_q);

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic rel_q;
  logic rel_d;

  assign rel_d = en && (state_q == ST_WAIT_RELEASE) && !s2 && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= rel_d;
    end
  end

  assign release_pulse = rel_q;
`endif

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: run-length reference model checked every cycle,
// directed timing cases pinned with literal edge counts, then randomized traffic.
module tb_debounce_pulse;

  localparam int SC = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic en = 1'b1;
  logic pulse, level, busy;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic release_pulse;
`endif

  int n_chk = 0;
  int n_fail = 0;

  debounce_pulse #(.STABLE_CYCLES(SC), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .en            (en),
    .pulse         (pulse),
    .level         (level),
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    .release_pulse (release_pulse),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the synchronized input has disagreed
  // with it for SC+1 consecutive enabled samples; any agreeing sample restarts.
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  logic m_level = 1'b0, m_pulse = 1'b0, m_rel = 1'b0;
  int   m_run = 0;
  bit   armed = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0;
        m_level = 1'b0; m_pulse = 1'b0; m_rel = 1'b0;
        armed = 1'b1;
      end else begin
        m_pulse = 1'b0;
        m_rel   = 1'b0;
        if (en) begin
          if (m_s2 != m_level) begin
            m_run++;
            if (m_run == SC + 1) begin
              m_level = m_s2;
              m_run   = 0;
              if (m_level) m_pulse = 1'b1;
              else         m_rel   = 1'b1;
            end
          end else begin
            m_run = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
      end
      #1;
      if (armed) begin
        chk("model_pulse", pulse, m_pulse);
        chk("model_level", level, m_level);
        chk("model_busy", busy, m_run != 0);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        chk("model_release_pulse", release_pulse, m_rel);
`endif
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; btn_in = 1'b0; en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int npulse;
    int nrel;

    // Reset state
    do_reset();
    chk("reset_pulse", pulse, 1'b0);
    chk("reset_level", level, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Clean press: pulse and level after edge 19
    @(negedge clk); btn_in = 1'b1;
    npulse = 0;
    for (int i = 1; i <= 40; i++) begin
      edge_sample();
      if (pulse) npulse++;
      if (i == 18) begin
        chk("clean_pulse_e18", pulse, 1'b0);
        chk("clean_level_e18", level, 1'b0);
      end
      if (i == 19) begin
        chk("clean_pulse_e19", pulse, 1'b1);
        chk("clean_level_e19", level, 1'b1);
        chk("model_pin_pulse_e19", m_pulse, 1'b1);
      end
      if (i == 20) chk("clean_pulse_e20", pulse, 1'b0);
    end
    chk_int("clean_pulse_count", npulse, 1);

    // Release: level drops after edge 19 from the first low sample
    @(negedge clk); btn_in = 1'b0;
    nrel = 0;
    for (int i = 1; i <= 40; i++) begin
      edge_sample();
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      if (release_pulse) nrel++;
      if (i == 19) chk("release_pulse_e19", release_pulse, 1'b1);
`endif
      if (i == 18) chk("release_level_e18", level, 1'b1);
      if (i == 19) begin
        chk("release_level_e19", level, 1'b0);
        chk("model_pin_level_e19", m_level, 1'b0);
      end
      chk("release_no_pulse", pulse, 1'b0);
    end
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    chk_int("release_pulse_count", nrel, 1);
`endif

    // Bounce: toggle every 3 cycles for 30, then high from cycle 31
    do_reset();
    npulse = 0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      btn_in = (c <= 30) ? ((((c - 1) / 3) % 2) == 0) : 1'b1;
      edge_sample();
      if (pulse) npulse++;
      if (c == 48) chk_int("bounce_no_early_pulse", npulse, 0);
      if (c == 49) chk("bounce_pulse_e49", pulse, 1'b1);
    end
    chk_int("bounce_pulse_count", npulse, 1);

    // Short glitch: 10 cycles high
    do_reset();
    @(negedge clk); btn_in = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) begin
        @(negedge clk); btn_in = 1'b0;
      end
      edge_sample();
      if (i == 5)  chk("glitch_busy_high", busy, 1'b1);
      if (i == 12) chk("glitch_busy_e12", busy, 1'b1);
      if (i == 13) chk("glitch_busy_e13", busy, 1'b0);
      chk("glitch_pulse", pulse, 1'b0);
      chk("glitch_level", level, 1'b0);
    end

    // Reset mid-count at cnt=8
    do_reset();
    @(negedge clk); btn_in = 1'b1;
    for (int i = 1; i <= 11; i++) edge_sample();
    chk("midrst_busy_before", busy, 1'b1);
    @(negedge clk); reset = 1'b0;
    edge_sample();
    chk("midrst_pulse", pulse, 1'b0);
    chk("midrst_level", level, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk); reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      edge_sample();
      if (i == 18) chk("midrst_pulse_e18", pulse, 1'b0);
      if (i == 19) chk("midrst_pulse_e19", pulse, 1'b1);
    end

    // Enable hold: en low for 5 edges in WAIT_PRESS delays pulse to edge 24
    do_reset();
    @(negedge clk); btn_in = 1'b1;
    for (int i = 1; i <= 5; i++) edge_sample();
    @(negedge clk); en = 1'b0;
    for (int i = 6; i <= 10; i++) begin
      edge_sample();
      if (i == 8) chk("en_hold_busy", busy, 1'b1);
    end
    @(negedge clk); en = 1'b1;
    for (int i = 11; i <= 26; i++) begin
      edge_sample();
      if (i == 19) chk("en_hold_pulse_e19", pulse, 1'b0);
      if (i == 23) chk("en_hold_pulse_e23", pulse, 1'b0);
      if (i == 24) begin
        chk("en_hold_pulse_e24", pulse, 1'b1);
        chk("model_pin_en_e24", m_pulse, 1'b1);
      end
    end

    // Randomized segments; model checks every cycle
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      int   len;
      logic b;
      len = $urandom_range(1, 40);
      b   = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        btn_in = b;
        en     = ($urandom_range(0, 9) != 0);
        reset  = ($urandom_range(0, 199) != 0);
      end
    end
    @(negedge clk); reset = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
